// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the sequential divider: datapath word width
// and the divider control state encoding.
package cpu_pkg;

    // Native datapath word width of the CPU.
    localparam int WORD_W = 32;

    // Divider control states.
    //   DIV_IDLE : waiting for start, operands captured on accept
    //   DIV_CALC : one restoring step per clock, WIDTH clocks total
    //   DIV_FIX  : sign correction of quotient and remainder, results written
    //   DIV_DONE : single-cycle completion pulse
    //   DIV_ZERO : single-cycle divide-by-zero completion, results untouched
    typedef enum logic [2:0] {
        DIV_IDLE = 3'd0,
        DIV_CALC = 3'd1,
        DIV_FIX  = 3'd2,
        DIV_DONE = 3'd3,
        DIV_ZERO = 3'd4
    } div_state_t;

endpackage : cpu_pkg

// File: rtl/div_step.sv
// One radix-2 restoring division step. The partial remainder and quotient
// register pair is shifted left by one; the divisor is trial-subtracted from
// the widened remainder and the subtraction is kept only when it does not
// borrow. The new quotient bit shifts in at the bottom.
//
// The partial remainder is always strictly less than the divisor, so the
// shifted value is below 2*divisor and one extra bit of headroom is enough
// for the trial subtraction.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] div,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           fits;

    // Shift, trial subtract, and restore when the trial goes negative.
    always_comb begin
        shifted  = {rem, quo[WIDTH-1]};
        trial    = shifted - {1'b0, div};
        fits     = ~trial[WIDTH];
        rem_next = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], fits};
    end

endmodule : div_step

// File: rtl/div_seq_unit.sv
// Multicycle integer divider for MIPS DIV/DIVU. Operands arrive from the
// DivSrcA/DivSrcB selects; the quotient is driven on lo_out and the remainder
// on hi_out toward the HI/LO registers.
//
// Signed division is done on operand magnitudes with a restoring unsigned
// core, then the quotient takes the XOR of the operand signs and the
// remainder takes the dividend's sign. This gives truncation toward zero.
// The most negative dividend has no positive counterpart; its magnitude is
// simply the same bit pattern read as unsigned, and the final negation wraps
// modulo 2^WIDTH, which yields the architecturally expected 0x80000000 for
// the 0x80000000 / -1 overflow case with no extra logic.
//
// Handshake: start is only looked at in IDLE; busy is high in every other
// state; done pulses for one cycle at completion; div_zero pulses alongside
// done when the divisor is zero, in which case hi_out/lo_out keep their
// previous contents.
module div_seq_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

    // Control and datapath state.
    div_state_t       state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] rem_acc;
    logic [WIDTH-1:0] quo_acc;
    logic [WIDTH-1:0] div_mag;
    logic             sign_q;
    logic             sign_r;

    // Combinational operand preparation, only consumed on the accept cycle.
    logic             dividend_neg;
    logic             divisor_neg;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic             divisor_is_zero;

    // Output of the single restoring step, iterated in time.
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;

    // Final sign-corrected results, written during FIX.
    logic [WIDTH-1:0] quo_fixed;
    logic [WIDTH-1:0] rem_fixed;

    // Operand magnitudes and signs; unsigned operands are passed straight through.
    always_comb begin
        dividend_neg    = is_signed & dividend[WIDTH-1];
        divisor_neg     = is_signed & divisor[WIDTH-1];
        dividend_mag    = dividend_neg ? (~dividend + 1'b1) : dividend;
        divisor_mag     = divisor_neg  ? (~divisor  + 1'b1) : divisor;
        divisor_is_zero = (divisor == '0);
    end

    // Sign correction of the unsigned core results, negation wraps at WIDTH bits.
    always_comb begin
        quo_fixed = sign_q ? (~quo_acc + 1'b1) : quo_acc;
        rem_fixed = sign_r ? (~rem_acc + 1'b1) : rem_acc;
    end

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem      (rem_acc),
        .quo      (quo_acc),
        .div      (div_mag),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    // Divider control FSM with registered handshake outputs and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= DIV_IDLE;
            count    <= CNT_ZERO;
            rem_acc  <= '0;
            quo_acc  <= '0;
            div_mag  <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi_out   <= '0;
            lo_out   <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    done     <= 1'b0;
                    div_zero <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (divisor_is_zero) begin
                            // Nothing to compute: report completion next cycle.
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                            state    <= DIV_ZERO;
                        end else begin
                            // Dividend magnitude starts in the quotient register and
                            // is shifted out into the remainder one bit per step.
                            quo_acc <= dividend_mag;
                            rem_acc <= '0;
                            div_mag <= divisor_mag;
                            sign_q  <= dividend_neg ^ divisor_neg;
                            sign_r  <= dividend_neg;
                            count   <= CNT_LAST;
                            state   <= DIV_CALC;
                        end
                    end
                end

                DIV_CALC: begin
                    rem_acc <= rem_step;
                    quo_acc <= quo_step;
                    if (count == CNT_ZERO) begin
                        state <= DIV_FIX;
                    end else begin
                        count <= count - CNT_ONE;
                    end
                end

                DIV_FIX: begin
                    lo_out <= quo_fixed;
                    hi_out <= rem_fixed;
                    done   <= 1'b1;
                    state  <= DIV_DONE;
                end

                DIV_DONE: begin
                    // Completion pulse ends here; start is not looked at this cycle.
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= DIV_IDLE;
                end

                DIV_ZERO: begin
                    done     <= 1'b0;
                    div_zero <= 1'b0;
                    busy     <= 1'b0;
                    state    <= DIV_IDLE;
                end

                default: begin
                    done     <= 1'b0;
                    div_zero <= 1'b0;
                    busy     <= 1'b0;
                    state    <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule : div_seq_unit

// File: tb/tb_div_seq_unit.sv
// Self-checking bench for div_seq_unit: directed corner cases followed by
// randomized DIV/DIVU operations, compared against plain integer arithmetic.
// Outputs are sampled 1 time unit after a rising edge, so a value seen there
// is the value present at the following edge.
module tb_div_seq_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi_out;
    logic [W-1:0] lo_out;

    int total = 0;
    int bad = 0;

    // Last successful results the unit is expected to be holding.
    logic [W-1:0] exp_hi = '0;
    logic [W-1:0] exp_lo = '0;

    div_seq_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .hi_out    (hi_out),
        .lo_out    (lo_out)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it when it does not match.
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: integer division in 64-bit arithmetic, truncating toward zero.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         output logic [W-1:0] q, output logic [W-1:0] r);
        longint na;
        longint nb;
        longint lq;
        longint lr;
        if (sgn) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'(a);
            nb = longint'(b);
        end
        lq = na / nb;
        lr = na % nb;
        q  = lq[W-1:0];
        r  = lr[W-1:0];
    endtask

    // Issue one operation and check latency, handshake and results.
    // With poke set, a second start with different operands is raised mid-run.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                          input bit poke, input string name);
        logic [W-1:0] q;
        logic [W-1:0] r;
        bit           is_zero;
        bit           busy_ok;
        int           cyc;
        q = '0;
        r = '0;
        is_zero = (b == '0);
        if (!is_zero) model(a, b, sgn, q, r);

        @(negedge clk);
        start     = 1'b1;
        dividend  = a;
        divisor   = b;
        is_signed = sgn;
        @(posedge clk);
        #1;
        // Scramble operands after capture; they must have no effect.
        start     = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = 1'($urandom_range(0, 1));

        cyc = 0;
        busy_ok = 1'b1;
        while (!done && cyc < 60) begin
            if (!busy) busy_ok = 1'b0;
            if (poke && cyc == 4) begin
                start     = 1'b1;
                dividend  = 32'd1000;
                divisor   = 32'd3;
                is_signed = 1'b0;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
        end
        if (!busy) busy_ok = 1'b0;

        if (!is_zero) begin
            exp_hi = r;
            exp_lo = q;
        end
        chk({name, " latency"}, 64'(cyc), is_zero ? 64'd0 : 64'(W + 1));
        chk({name, " busy"}, 64'(busy_ok), 64'd1);
        chk({name, " lo"}, 64'(lo_out), 64'(exp_lo));
        chk({name, " hi"}, 64'(hi_out), 64'(exp_hi));
        chk({name, " div_zero"}, 64'(div_zero), 64'(is_zero));
        $display("op %s a=0x%08h b=0x%08h s=%0d lo=0x%08h hi=0x%08h dz=%0d cyc=%0d",
                 name, a, b, sgn, lo_out, hi_out, div_zero, cyc);

        @(posedge clk);
        #1;
        chk({name, " done_end"}, 64'(done), 64'd0);
        chk({name, " busy_end"}, 64'(busy), 64'd0);
        chk({name, " dz_end"}, 64'(div_zero), 64'd0);
    endtask

    // Pick an operand, biased toward the interesting boundary patterns.
    function automatic logic [W-1:0] pick(input bit allow_zero);
        int sel;
        sel = int'($urandom_range(0, 9));
        case (sel)
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return allow_zero ? 32'h0 : 32'h1;
            3: return 32'h1;
            4: return 32'(int'($urandom_range(1, 20)));
            5: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit no_done;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst div_zero", 64'(div_zero), 64'd0);
        chk("rst hi", 64'(hi_out), 64'd0);
        chk("rst lo", 64'(lo_out), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Directed cases.
        run_op(32'd100, 32'd7, 1'b0, 1'b0, "divu_100_7");
        chk("divu_100_7 q", 64'(lo_out), 64'd14);
        chk("divu_100_7 r", 64'(hi_out), 64'd2);
        run_op(32'd0, 32'd0, 1'b0, 1'b0, "div0_hold");
        chk("div0_hold lo", 64'(lo_out), 64'd14);
        chk("div0_hold hi", 64'(hi_out), 64'd2);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, "div_m7_2");
        chk("div_m7_2 q", 64'(lo_out), 64'hFFFF_FFFD);
        chk("div_m7_2 r", 64'(hi_out), 64'hFFFF_FFFF);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "divu_m7_2");
        chk("divu_m7_2 q", 64'(lo_out), 64'h7FFF_FFFC);
        chk("divu_m7_2 r", 64'(hi_out), 64'd1);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, "div_ovf");
        chk("div_ovf q", 64'(lo_out), 64'h8000_0000);
        chk("div_ovf r", 64'(hi_out), 64'd0);
        run_op(32'h8000_0000, 32'd1, 1'b1, 1'b0, "div_min_1");
        chk("div_min_1 q", 64'(lo_out), 64'h8000_0000);
        run_op(32'd100, 32'd7, 1'b0, 1'b1, "poke_busy");
        chk("poke_busy q", 64'(lo_out), 64'd14);
        chk("poke_busy r", 64'(hi_out), 64'd2);

        // Reset asserted mid-calculation: everything clears at once, no completion.
        @(negedge clk);
        start     = 1'b1;
        dividend  = 32'd12345;
        divisor   = 32'd11;
        is_signed = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst busy", 64'(busy), 64'd0);
        chk("midrst hi", 64'(hi_out), 64'd0);
        chk("midrst lo", 64'(lo_out), 64'd0);
        exp_hi = '0;
        exp_lo = '0;
        no_done = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) no_done = 1'b0;
        end
        chk("midrst no_done", 64'(no_done), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        run_op(32'd9, 32'd3, 1'b0, 1'b0, "after_rst");
        chk("after_rst q", 64'(lo_out), 64'd3);
        chk("after_rst r", 64'(hi_out), 64'd0);

        // Randomized operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic         s;
            a = pick(1'b1);
            b = (int'($urandom_range(0, 9)) == 0) ? 32'h0 : pick(1'b0);
            s = 1'($urandom_range(0, 1));
            run_op(a, b, s, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_div_seq_unit
